// File: rtl/ft2_fifo_responder_pkg.sv
// Shared types for the FT2 device-side responder: FSM state encodings and gap counter width.
package ft2_fifo_responder_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_AVAIL = 2'd1,
    RX_READ  = 2'd2,
    RX_GAP   = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_READY = 2'd0,
    TX_HOLD  = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_e;

  localparam int unsigned GAP_W = 8;

endpackage

// File: rtl/ft2_fifo_responder_fifo.sv
// Show-ahead synchronous byte FIFO with full/empty/count; push while full and pop while empty are ignored.
module sync_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage is not reset; pointer reset is what discards contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ft2_fifo_responder.sv
// Device-side FT2 async FIFO model: answers rd_n/wr_n strobes from the FPGA engine, backed by host-side byte FIFOs.
module ft2_fifo_responder
  import ft2_fifo_responder_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RXF_GAP  = 4,
  parameter int unsigned TXE_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire  [7:0] ft2_data,
  input  logic       ft2_rd_n,
  input  logic       ft2_wr_n,
  output logic       ft2_rxf_n,
  output logic       ft2_txe_n,
  input  logic       host_wr_valid,
  input  logic [7:0] host_wr_data,
  output logic       host_wr_ready,
  output logic       host_rd_valid,
  output logic [7:0] host_rd_data,
  input  logic       host_rd_en,
  output logic       protocol_err
);

  rx_state_e          rx_q, rx_d;
  tx_state_e          tx_q, tx_d;
  logic [GAP_W-1:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic               rd_q, wr_q, err_q;
  logic               conflict, rx_pop, tx_push, rx_drive;
  logic               rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]         rx_head, tx_head;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic               unused_counts;

  assign unused_counts = ^{rx_count, tx_count};
  assign conflict      = !ft2_rd_n && !ft2_wr_n;
  assign protocol_err  = err_q;

  sync_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(host_wr_valid), .din_i(host_wr_data),
    .pop_i(rx_pop), .dout_o(rx_head),
    .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  sync_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(tx_push), .din_i(ft2_data),
    .pop_i(host_rd_en), .dout_o(tx_head),
    .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  assign host_wr_ready = !rx_full;
  assign host_rd_valid = !tx_empty;
  assign host_rd_data  = tx_empty ? '0 : tx_head;

  // A conflict has wr_n low, so the wr_n term also releases the bus then.
  assign rx_drive = ((rx_q == RX_AVAIL) || (rx_q == RX_READ)) && !ft2_rd_n && ft2_wr_n;
  assign ft2_data = rx_drive ? rx_head : 'z;

  always_comb begin
    rx_d      = rx_q;
    rx_cnt_d  = rx_cnt_q;
    rx_pop    = 1'b0;
    ft2_rxf_n = 1'b1;
    case (rx_q)
      RX_IDLE: if (!rx_empty) rx_d = RX_AVAIL;
      RX_AVAIL: begin
        ft2_rxf_n = 1'b0;
        if (!ft2_rd_n && !conflict) rx_d = RX_READ;
      end
      RX_READ: begin
        ft2_rxf_n = 1'b0;
        if (ft2_rd_n && !rd_q) begin
          rx_pop   = 1'b1;
          rx_cnt_d = GAP_W'(RXF_GAP - 1);
          rx_d     = RX_GAP;
        end
      end
      RX_GAP: begin
        if (rx_cnt_q == '0) rx_d = RX_IDLE;
        else                rx_cnt_d = rx_cnt_q - GAP_W'(1);
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // txe_n is forced high while reset is held so the reset value is seen on the pin.
  always_comb begin
    tx_d      = tx_q;
    tx_cnt_d  = tx_cnt_q;
    tx_push   = 1'b0;
    ft2_txe_n = 1'b1;
    case (tx_q)
      TX_READY: begin
        ft2_txe_n = tx_full || !rst_n;
        if (!ft2_wr_n && wr_q && !tx_full && !conflict) begin
          tx_push = 1'b1;
          tx_d    = TX_HOLD;
        end
      end
      TX_HOLD: begin
        if (ft2_wr_n) begin
          tx_cnt_d = GAP_W'(TXE_GAP - 1);
          tx_d     = TX_GAP;
        end
      end
      TX_GAP: begin
        if (tx_cnt_q == '0) tx_d = TX_READY;
        else                tx_cnt_d = tx_cnt_q - GAP_W'(1);
      end
      default: tx_d = TX_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q     <= RX_IDLE;
      tx_q     <= TX_READY;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      rd_q     <= ft2_rd_n;
      wr_q     <= ft2_wr_n;
      err_q    <= err_q || conflict;
    end
  end

endmodule

// File: tb/tb_ft2_fifo_responder.sv
// Scoreboard bench for ft2_fifo_responder: expected bytes queued at stimulus time, checked by monitors/readers.
module tb_ft2_fifo_responder;

  logic       clk;
  logic       rst_n;
  wire  [7:0] ft2_data;
  logic       ft2_rd_n, ft2_wr_n;
  logic       ft2_rxf_n, ft2_txe_n;
  logic       host_wr_valid, host_wr_ready;
  logic [7:0] host_wr_data;
  logic       host_rd_valid, host_rd_en;
  logic [7:0] host_rd_data;
  logic       protocol_err;
  logic       eng_oe;
  logic [7:0] eng_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  assign ft2_data = eng_oe ? eng_data : 8'hzz;

  ft2_fifo_responder #(
    .RX_DEPTH(16), .TX_DEPTH(16), .RXF_GAP(4), .TXE_GAP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ft2_data(ft2_data),
    .ft2_rd_n(ft2_rd_n), .ft2_wr_n(ft2_wr_n),
    .ft2_rxf_n(ft2_rxf_n), .ft2_txe_n(ft2_txe_n),
    .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data), .host_rd_en(host_rd_en),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // TX-side monitor: every host pop of a presented byte is scored against the queue.
  always @(negedge clk) begin
    if (rst_n && host_rd_en && host_rd_valid) begin
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got %0h expected none", host_rd_data);
      end else begin
        logic [7:0] e;
        e = exp_tx.pop_front();
        if (host_rd_data !== e) begin
          errors++;
          $display("FAIL tx_data got %0h expected %0h", host_rd_data, e);
        end
      end
    end
  end

  task automatic check_rx(input logic [7:0] got);
    logic [7:0] e;
    checks++;
    if (exp_rx.size() == 0) begin
      errors++;
      $display("FAIL rx_unexpected got %0h expected none", got);
    end else begin
      e = exp_rx.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL rx_data got %0h expected %0h", got, e);
      end
    end
  endtask

  task automatic eng_read();
    logic [7:0]  got;
    int unsigned n;
    n = 0;
    while (ft2_rxf_n && n < 50) begin step(); n++; end
    if (ft2_rxf_n) begin
      checks++; errors++;
      $display("FAIL rd_timeout got rxf_n=1 expected 0");
    end else begin
      ft2_rd_n = 1'b0;
      step();
      got = ft2_data;
      ft2_rd_n = 1'b1;
      step();
      check_rx(got);
    end
  endtask

  task automatic eng_write(input logic [7:0] d, input bit expect_ok);
    int unsigned n;
    n = 0;
    if (expect_ok) begin
      while (ft2_txe_n && n < 50) begin step(); n++; end
      if (ft2_txe_n) begin
        checks++; errors++;
        $display("FAIL wr_timeout got txe_n=1 expected 0");
      end
      exp_tx.push_back(d);
    end
    eng_data = d; eng_oe = 1'b1;
    step();
    ft2_wr_n = 1'b0;
    step();
    ft2_wr_n = 1'b1;
    step();
    eng_oe = 1'b0;
  endtask

  task automatic host_push_burst(input logic [7:0] base, input int unsigned cnt);
    int unsigned n;
    for (int unsigned i = 0; i < cnt; i++) begin
      host_wr_data  = base + 8'(i);
      host_wr_valid = 1'b1;
      n = 0;
      while (!host_wr_ready && n < 100) begin step(); n++; end
      if (!host_wr_ready) begin
        checks++; errors++;
        $display("FAIL push_timeout got ready=0 expected 1");
      end
      exp_rx.push_back(host_wr_data);
      step();
    end
    host_wr_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ft2_rd_n = 1'b1; ft2_wr_n = 1'b1;
    eng_oe = 1'b0; eng_data = '0;
    host_wr_valid = 1'b0; host_wr_data = '0; host_rd_en = 1'b0;
    repeat (3) step();
    check("rst_rxf_n", ft2_rxf_n, 1);
    check("rst_txe_n", ft2_txe_n, 1);
    check("rst_wr_ready", host_wr_ready, 1);
    check("rst_rd_valid", host_rd_valid, 0);
    check("rst_rd_data", host_rd_data, 0);
    check("rst_perr", protocol_err, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_txe_n", ft2_txe_n, 0);

    // Single host byte read by the engine
    host_wr_data = 8'hA5; host_wr_valid = 1'b1; exp_rx.push_back(8'hA5);
    step();
    host_wr_valid = 1'b0;
    check("a5_rxf_1cyc", ft2_rxf_n, 1);
    step();
    check("a5_rxf_2cyc", ft2_rxf_n, 0);
    eng_read();
    for (int i = 0; i < 4; i++) begin
      check("a5_rxf_gap", ft2_rxf_n, 1);
      step();
    end
    repeat (3) step();
    check("a5_rxf_empty", ft2_rxf_n, 1);

    // wr_n held low three cycles is one write
    eng_data = 8'h3C; eng_oe = 1'b1; exp_tx.push_back(8'h3C);
    step();
    ft2_wr_n = 1'b0;
    step();
    check("3c_txe_capt", ft2_txe_n, 1);
    check("3c_rd_valid", host_rd_valid, 1);
    step(); step();
    ft2_wr_n = 1'b1; eng_oe = 1'b0;
    step();
    check("3c_txe_gap1", ft2_txe_n, 1);
    step();
    check("3c_txe_gap2", ft2_txe_n, 1);
    step();
    check("3c_txe_open", ft2_txe_n, 0);
    host_rd_en = 1'b1;
    step();
    host_rd_en = 1'b0;
    check("3c_one_byte", host_rd_valid, 0);

    // Fill TX FIFO, 17th write dropped, one pop reopens
    for (int i = 0; i < 16; i++) eng_write(8'(i), 1'b1);
    repeat (4) step();
    check("tx_full_txe", ft2_txe_n, 1);
    eng_write(8'hEE, 1'b0);
    check("tx_full_txe2", ft2_txe_n, 1);
    host_rd_en = 1'b1;
    step();
    host_rd_en = 1'b0;
    check("tx_reopen_txe", ft2_txe_n, 0);
    host_rd_en = 1'b1;
    repeat (15) step();
    host_rd_en = 1'b0;
    check("tx_drained", host_rd_valid, 0);

    // Full-rate host pushes concurrent with engine reads
    fork
      host_push_burst(8'h10, 16);
      begin
        for (int j = 0; j < 16; j++) eng_read();
      end
    join

    // RX ready boundary at 16 entries
    repeat (8) step();
    host_push_burst(8'h20, 15);
    check("rx_ready_15", host_wr_ready, 1);
    host_push_burst(8'h2F, 1);
    check("rx_ready_16", host_wr_ready, 0);
    host_wr_data = 8'hEE; host_wr_valid = 1'b1;
    step(); step();
    host_wr_valid = 1'b0;
    check("rx_ready_still0", host_wr_ready, 0);
    for (int j = 0; j < 16; j++) eng_read();
    repeat (8) step();
    check("rx_no_extra", ft2_rxf_n, 1);

    // Protocol error: both strobes low
    host_wr_data = 8'h77; host_wr_valid = 1'b1; exp_rx.push_back(8'h77);
    step();
    host_wr_valid = 1'b0;
    step();
    check("perr_pre", protocol_err, 0);
    ft2_rd_n = 1'b0; ft2_wr_n = 1'b0; eng_data = 8'h99; eng_oe = 1'b1;
    step();
    check("perr_set", protocol_err, 1);
    ft2_rd_n = 1'b1; ft2_wr_n = 1'b1; eng_oe = 1'b0;
    step();
    check("perr_tx_unch", host_rd_valid, 0);
    check("perr_rx_unch", ft2_rxf_n, 0);
    eng_read();
    repeat (5) step();
    check("perr_sticky", protocol_err, 1);

    // Reset during RX_READ with bytes queued in both directions
    eng_write(8'h55, 1'b0);
    check("rst_tx_has", host_rd_valid, 1);
    host_push_burst(8'h41, 3);
    step();
    check("rst_rxf_low", ft2_rxf_n, 0);
    ft2_rd_n = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    exp_rx.delete();
    check("mid_rst_rxf", ft2_rxf_n, 1);
    check("mid_rst_rd_valid", host_rd_valid, 0);
    check("mid_rst_wr_ready", host_wr_ready, 1);
    check("mid_rst_perr", protocol_err, 0);
    ft2_rd_n = 1'b1; rst_n = 1'b1;
    repeat (6) step();
    check("after_rst_rxf", ft2_rxf_n, 1);
    check("after_rst_rd_valid", host_rd_valid, 0);
    check("after_rst_txe", ft2_txe_n, 0);

    check("exp_rx_empty", exp_rx.size(), 0);
    check("exp_tx_empty", exp_tx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
